// File: rtl/jt7759_pkg.sv
// jt7759_pkg
// Shared definitions for the JT7759 ROM response buffer:
//   - rom_state_t : fetch FSM encoding (IDLE / DEMAND / PREF)
//   - BYTE_SEL_BIT: byte-address bit that picks the lane inside a 16-bit word
//   - byte_lane() : lane extraction helper (0 -> [7:0], 1 -> [15:8])
package jt7759_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEMAND = 2'd1,
    PREF   = 2'd2
  } rom_state_t;

  localparam int BYTE_SEL_BIT = 0;

  function automatic logic [7:0] byte_lane(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/jt7759_rom_entry.sv
// jt7759_rom_entry
// One word entry of the ROM response buffer: tag, valid bit and data word.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   wr_i      : load tag_i/data_i and mark the entry valid
//   inv_i     : clear the valid bit (wins over wr_i in the same cycle)
//   tag_i     : word address being stored
//   data_i    : word being stored
//   valid_o   : entry holds a usable word
//   tag_o     : stored word address
//   data_o    : stored word
module jt7759_rom_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_i,
  input  logic        inv_i,
  input  logic [15:0] tag_i,
  input  logic [15:0] data_i,
  output logic        valid_o,
  output logic [15:0] tag_o,
  output logic [15:0] data_o
);

  logic        valid_q;
  logic [15:0] tag_q;
  logic [15:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= 16'h0000;
      data_q  <= 16'h0000;
    end else if (inv_i) begin
      valid_q <= 1'b0;
    end else if (wr_i) begin
      valid_q <= 1'b1;
      tag_q   <= tag_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;

endmodule

// File: rtl/jt7759_rom_rsp.sv
// jt7759_rom_rsp
// Two-entry word buffer between the ADPCM byte requester and a 16-bit memory.
// Hits answer one clock after the request; misses fetch the word and, with
// PREFETCH=1, follow every demand fill with a fetch of the next word.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   rom_cs     : byte request strobe
//   rom_addr   : requested byte address (17 bits)
//   flush      : invalidate both entries and any outstanding fill
//   rom_data   : returned byte (registered)
//   rom_ok     : rom_data belongs to the current rom_addr
//   mem_req    : word fetch request
//   mem_addr   : word address of the fetch
//   mem_data   : fetched word, valid with mem_ok
//   mem_ok     : one-cycle fetch-complete pulse
//   dbg_state  : current fetch FSM state
//
// Memory handshake: mem_req rises with mem_addr and both stay unchanged until
// the cycle mem_ok is seen high; mem_req then drops for at least one cycle
// before the next fetch. mem_ok while mem_req is low carries no meaning and is
// ignored. A fetch, once issued, is never withdrawn.
module jt7759_rom_rsp
  import jt7759_pkg::*;
#(
  parameter int PREFETCH = 1,
  parameter int MEM_AW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_cs,
  input  logic [16:0]       rom_addr,
  input  logic              flush,
  output logic [7:0]        rom_data,
  output logic              rom_ok,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  input  logic              mem_ok,
  output logic [1:0]        dbg_state
);

  rom_state_t  state_q, state_d;
  logic        lru_q, lru_d;           // entry to replace on the next demand fill
  logic        drop_q, drop_d;         // outstanding fill was flushed
  logic        ok_q, ok_d;
  logic [16:0] ok_addr_q, ok_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] fetch_tag_q, fetch_tag_d;
  logic        fill_idx_q, fill_idx_d;

  logic [1:0]  ent_valid;
  logic [15:0] ent_tag  [2];
  logic [15:0] ent_data [2];
  logic [1:0]  ent_wr;

  for (genvar g = 0; g < 2; g++) begin : g_entry
    jt7759_rom_entry u_entry (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (ent_wr[g]),
      .inv_i   (flush),
      .tag_i   (fetch_tag_q),
      .data_i  (mem_data),
      .valid_o (ent_valid[g]),
      .tag_o   (ent_tag[g]),
      .data_o  (ent_data[g])
    );
  end

  logic [15:0] req_tag;
  logic        hit0, hit1, hit_any;
  logic [15:0] hit_word;
  logic        fill_ok;
  logic        other_idx;
  logic [15:0] next_tag;
  logic        next_in_other;

  assign req_tag   = rom_addr[16:1];
  assign hit0      = ent_valid[0] && (ent_tag[0] == req_tag);
  assign hit1      = ent_valid[1] && (ent_tag[1] == req_tag);
  assign hit_any   = hit0 || hit1;
  assign hit_word  = hit1 ? ent_data[1] : ent_data[0];
  assign fill_ok   = mem_req_q && mem_ok;
  assign other_idx = ~fill_idx_q;
  // 16'hFFFF + 1 wraps to 16'h0000, the intended successor of the last word.
  assign next_tag  = fetch_tag_q + 16'd1;
  assign next_in_other = ent_valid[other_idx] && (ent_tag[other_idx] == next_tag);

  // Response path: flush beats a hit; a held ok survives only while the
  // requester keeps the same address with cs high.
  always_comb begin
    ok_d       = ok_q;
    ok_addr_d  = ok_addr_q;
    rom_data_d = rom_data_q;
    if (flush) begin
      ok_d = 1'b0;
    end else if (rom_cs && hit_any) begin
      ok_d       = 1'b1;
      ok_addr_d  = rom_addr;
      rom_data_d = byte_lane(hit_word, rom_addr[BYTE_SEL_BIT]);
    end else if (!rom_cs || (rom_addr != ok_addr_q)) begin
      ok_d = 1'b0;
    end
  end

  // Fetch FSM. A demand miss seen during PREF just waits: once the prefetch
  // lands the FSM is back in IDLE and the still-missing request starts DEMAND.
  // A request for the word being prefetched becomes a hit when that fill lands.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    fetch_tag_d = fetch_tag_q;
    fill_idx_d  = fill_idx_q;
    lru_d       = lru_q;
    drop_d      = drop_q;
    ent_wr      = 2'b00;
    case (state_q)
      IDLE: begin
        if (rom_cs && !hit_any && !flush) begin
          fetch_tag_d = req_tag;
          fill_idx_d  = lru_q;
          mem_req_d   = 1'b1;
          state_d     = DEMAND;
        end
      end
      DEMAND: begin
        if (fill_ok) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (drop_q || flush) begin
            state_d = IDLE;
          end else begin
            ent_wr[fill_idx_q] = 1'b1;
            lru_d              = other_idx;
            // Prefetch goes to the other entry so the demanded word stays.
            if ((PREFETCH != 0) && !next_in_other) begin
              fetch_tag_d = next_tag;
              fill_idx_d  = other_idx;
              state_d     = PREF;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      PREF: begin
        if (!mem_req_q) begin
          // First PREF cycle: mem_req has dropped after the demand fill.
          if (flush) begin
            state_d = IDLE;
          end else begin
            mem_req_d = 1'b1;
          end
        end else if (fill_ok) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          state_d   = IDLE;
          if (!drop_q && !flush) begin
            ent_wr[fill_idx_q] = 1'b1;
            lru_d              = other_idx;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lru_q       <= 1'b0;
      drop_q      <= 1'b0;
      ok_q        <= 1'b0;
      ok_addr_q   <= 17'h00000;
      rom_data_q  <= 8'h00;
      mem_req_q   <= 1'b0;
      fetch_tag_q <= 16'h0000;
      fill_idx_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lru_q       <= lru_d;
      drop_q      <= drop_d;
      ok_q        <= ok_d;
      ok_addr_q   <= ok_addr_d;
      rom_data_q  <= rom_data_d;
      mem_req_q   <= mem_req_d;
      fetch_tag_q <= fetch_tag_d;
      fill_idx_q  <= fill_idx_d;
    end
  end

  assign rom_ok    = ok_q && rom_cs && (rom_addr == ok_addr_q);
  assign rom_data  = rom_data_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = MEM_AW'(fetch_tag_q);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_jt7759_rom_rsp.sv
// tb_jt7759_rom_rsp
// Directed bench for jt7759_rom_rsp with a latency-programmable word memory,
// a fetch log and an expected-byte queue.
module tb_jt7759_rom_rsp;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic        flush;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_data = 16'hDEAD;
  logic        mem_ok   = 1'b0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  jt7759_rom_rsp dut (
    .clk       (clk),
    .rst       (rst),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .flush     (flush),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ok    (mem_ok),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] fetch_log[$];

  function automatic logic [15:0] word_fn(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'd40503;
    return m ^ 16'h1D2B;
  endfunction

  function automatic logic [7:0] byte_exp(input logic [16:0] a);
    logic [15:0] w;
    w = word_fn(a[16:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < fetch_log.size()) return 32'(fetch_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  // Latches mem_addr when a request appears, pulses mem_ok mem_lat cycles
  // later (counted from the first cycle mem_req is seen), then idles a cycle.
  // Once started it completes even if the DUT is reset meanwhile.
  int          mem_lat = 4;
  logic        busy    = 1'b0;
  int          cnt     = 0;
  logic [15:0] req_word = 16'h0000;

  always @(negedge clk) begin
    if (mem_ok) begin
      mem_ok   = 1'b0;
      mem_data = 16'hDEAD;
      busy     = 1'b0;
    end else begin
      if (!busy && mem_req) begin
        busy     = 1'b1;
        cnt      = 0;
        req_word = mem_addr;
        fetch_log.push_back(mem_addr);
      end
      if (busy) begin
        cnt++;
        if (cnt >= mem_lat) begin
          if (mem_req) check("mem_addr_stable", 32'(mem_addr), 32'(req_word));
          mem_ok   = 1'b1;
          mem_data = word_fn(req_word);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_req(input logic [16:0] a);
    rom_cs   = 1'b1;
    rom_addr = a;
    exp_q.push_back(byte_exp(a));
  endtask

  task automatic wait_ok(input string tag, input int budget, output int lat);
    logic [7:0] e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rom_ok !== 1'b1 && lat < budget);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_ok"}, 32'(rom_ok), 32'd1);
    check({tag, "_data"}, 32'(rom_data), 32'(e));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_gap();
    rom_cs = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    rst      = 1'b1;
    rom_cs   = 1'b0;
    rom_addr = 17'h00000;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rom_ok",   32'(rom_ok),    32'd0);
    check("rst_rom_data", 32'(rom_data),  32'h00);
    check("rst_mem_req",  32'(mem_req),   32'd0);
    check("rst_mem_addr", 32'(mem_addr),  32'h0000);
    check("rst_state",    32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss on byte 5 (word 2, upper lane), memory latency 4.
    mem_lat = 4;
    issue_req(17'h00005);
    wait_ok("cold", 40, lat);
    check("cold_lat", 32'(lat), 32'd6);
    check("cold_fetch_addr", log_at(0), 32'h0002);
    idle_cycles(10);
    check("cold_pref_cnt",  32'(fetch_log.size()), 32'd2);
    check("cold_pref_addr", log_at(1), 32'h0003);

    // Sequential hit from the prefetched word after a cs gap.
    cs_gap();
    check("cs_low_ok", 32'(rom_ok), 32'd0);
    issue_req(17'h00006);
    wait_ok("hit6", 10, lat);
    check("hit6_lat", 32'(lat), 32'd1);

    // Address change with cs held: rom_ok drops immediately.
    issue_req(17'h00007);
    #1;
    check("addr_change_drop", 32'(rom_ok), 32'd0);
    wait_ok("hit7", 10, lat);
    check("hit7_lat", 32'(lat), 32'd1);
    check("seq_no_fetch", 32'(fetch_log.size()), 32'd2);

    // Same address after a cs gap: held ok must have been cleared.
    cs_gap();
    issue_req(17'h00007);
    #1;
    check("ok_cleared_by_cs", 32'(rom_ok), 32'd0);
    wait_ok("rehit7", 10, lat);
    check("rehit7_lat", 32'(lat), 32'd1);

    // Wrap: last word prefetches word 0.
    cs_gap();
    mem_lat = 3;
    issue_req(17'h1FFFF);
    wait_ok("wrap_miss", 40, lat);
    check("wrap_lat", 32'(lat), 32'd5);
    idle_cycles(10);
    check("wrap_fetch_cnt",  32'(fetch_log.size()), 32'd4);
    check("wrap_demand_addr", log_at(2), 32'hFFFF);
    check("wrap_pref_addr",   log_at(3), 32'h0000);
    cs_gap();
    issue_req(17'h00000);
    wait_ok("wrap_hit0", 10, lat);
    check("wrap_hit0_lat", 32'(lat), 32'd1);
    issue_req(17'h00001);
    wait_ok("wrap_hit1", 10, lat);
    check("wrap_hit1_lat", 32'(lat), 32'd1);

    // No fetch while cs is low, even on a missing address.
    rom_cs   = 1'b0;
    rom_addr = 17'h0ABCD;
    idle_cycles(6);
    check("no_fetch_cs_low", 32'(fetch_log.size()), 32'd4);

    // Miss while the prefetch of word 3 is outstanding.
    mem_lat = 6;
    issue_req(17'h00005);
    wait_ok("pref_base", 40, lat);
    check("pref_base_lat", 32'(lat), 32'd8);
    issue_req(17'h01000);
    wait_ok("miss_in_pref", 60, lat);
    check("miss_in_pref_wait", 32'(lat >= 12), 32'd1);
    check("miss_in_pref_first",  log_at(5), 32'h0003);
    check("miss_in_pref_second", log_at(6), 32'h0800);

    // Demand for the word being prefetched: served from that fill.
    issue_req(17'h01002);
    wait_ok("pref_match", 40, lat);
    idle_cycles(10);
    check("pref_match_cnt",  32'(fetch_log.size()), 32'd8);
    check("pref_match_addr", log_at(7), 32'h0801);

    // Flush during DEMAND, mem_ok three clocks after the flush.
    cs_gap();
    mem_lat = 5;
    issue_req(17'h00400);
    idle_cycles(2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_ok("flush_refetch", 60, lat);
    idle_cycles(10);
    check("flush_fetch_cnt", 32'(fetch_log.size()), 32'd11);
    check("flush_first",     log_at(8),  32'h0200);
    check("flush_refetch",   log_at(9),  32'h0200);
    check("flush_pref",      log_at(10), 32'h0201);

    // Flush with the word present: ok drops and both entries are refetched.
    flush = 1'b1;
    issue_req(17'h00400);
    @(negedge clk);
    flush = 1'b0;
    check("flush_clears_ok", 32'(rom_ok), 32'd0);
    wait_ok("after_flush", 60, lat);
    idle_cycles(10);
    check("inv_fetch_cnt",  32'(fetch_log.size()), 32'd13);
    check("inv_demand",     log_at(11), 32'h0200);
    check("inv_other_pref", log_at(12), 32'h0201);

    // Reset in the middle of a fetch; the late mem_ok must be ignored.
    cs_gap();
    mem_lat  = 6;
    rom_cs   = 1'b1;
    rom_addr = 17'h03000;
    idle_cycles(2);
    rst    = 1'b1;
    rom_cs = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(mem_req),   32'd0);
    check("rst_mid_rom_ok",  32'(rom_ok),    32'd0);
    check("rst_mid_state",   32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(8);
    check("late_ok_state",   32'(dbg_state), 32'd0);
    check("late_ok_mem_req", 32'(mem_req),   32'd0);
    issue_req(17'h03000);
    wait_ok("after_reset", 40, lat);
    check("after_reset_lat",  32'(lat), 32'd8);
    check("after_reset_addr", log_at(14), 32'h1800);

    cs_gap();
    idle_cycles(10);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jt7759_rom_rsp.md
JT7759_ROM_RSP -- requirements
Module: jt7759_rom_rsp

Interface
REQ-001 SHALL have parameter PREFETCH, default 1, meaning 1 enables next-word prefetch after every demand fill.
REQ-002 SHALL have parameter MEM_AW, default 16, meaning the external memory word-address width (byte space = MEM_AW+1 = 17 bits).
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-005 SHALL have port rom_cs, input, 1, the byte-request strobe from the ADPCM controller.
REQ-006 SHALL have port rom_addr, input, 17, the requested byte address.
REQ-007 SHALL have port flush, input, 1, which invalidates the buffer.
REQ-008 SHALL have port rom_data, output, 8, the returned byte.
REQ-009 SHALL have port rom_ok, output, 1, meaning rom_data is valid for the current rom_addr.
REQ-010 SHALL have port mem_req, output, 1, the word-fetch request.
REQ-011 SHALL have port mem_addr, output, MEM_AW, the word address.
REQ-012 SHALL have port mem_data, input, 16, the fetched word.
REQ-013 SHALL have port mem_ok, input, 1, a one-cycle fetch-complete pulse.

Function
REQ-014 SHALL hold two word entries, each with tag[15:0], valid and data[15:0], plus one LRU bit.
REQ-015 SHALL select the byte so that rom_addr[0]=0 returns word[7:0] and rom_addr[0]=1 returns word[15:8].
REQ-016 SHALL, on hit (rom_cs=1, valid tag==rom_addr[16:1]), register rom_data and set ok_addr<=rom_addr and ok_reg<=1 one cycle later, giving latency 1 clk.
REQ-017 SHALL drive rom_ok = ok_reg & rom_cs & (rom_addr==ok_addr), so rom_ok is never high for a stale address or while cs is low.
REQ-018 SHALL clear ok_reg on any cycle where rom_cs=0 or rom_addr!=ok_addr.
REQ-019 SHALL implement FSM IDLE, DEMAND and PREF.
REQ-020 SHALL, in IDLE on a miss, load mem_addr<=rom_addr[16:1], set mem_req=1 and go to DEMAND.
REQ-021 SHALL, in DEMAND on mem_ok, write the LRU entry, flip LRU, clear mem_req the next cycle and serve the hit the following cycle, giving miss latency = mem latency + 2 clk.
REQ-022 SHALL, when PREFETCH=1 and word W+1 (mod 2^16; 16'hFFFF wraps to 0) is not valid after a DEMAND fill of word W, issue a fetch of W+1 into the other entry (state PREF) without evicting W.
REQ-023 SHALL hold mem_req and mem_addr stable until mem_ok; mem_ok while mem_req=0 SHALL be ignored; transactions are never aborted.
REQ-024 SHALL, on a demand miss arriving during PREF, complete the prefetch, store it, then enter DEMAND; a demand matching the in-flight prefetch address SHALL be served from that fill with no second fetch.
REQ-025 SHALL, on flush, clear both valid bits and ok_reg in the same cycle.
REQ-026 SHALL, when flush occurs with a fetch outstanding, set drop=1, discard that fill on mem_ok and return to IDLE.
REQ-027 SHALL give flush priority over a simultaneous hit or fill, and re-fetch any demand still pending afterwards.
REQ-028 SHALL not start a fetch in IDLE while rom_cs=0.
REQ-029 SHALL not start a prefetch while flush=1.

Reset
REQ-030 SHALL, while rst=1, force state=IDLE, valid=0 (both entries), LRU=0, drop=0, ok_reg=0, rom_ok=0, rom_data=8'h00, mem_req=0 and mem_addr=0.
REQ-031 SHALL, on rst assertion mid-transaction, abandon the transaction; a late mem_ok after release SHALL be ignored because mem_req=0.

Structure
REQ-032 SHALL place the state encoding localparams (IDLE/DEMAND/PREF) and the byte-lane select constant in shared package jt7759_pkg.
REQ-033 SHALL implement each buffer entry (tag/valid/data, write and invalidate) as one sub-module, jt7759_rom_entry, instantiated twice.

Verification
REQ-034 Cold miss: rom_cs=1, addr 17'h00005, mem latency 4 -> mem_addr=16'h0002 held until mem_ok; rom_data=word[15:8], rom_ok high 2 clk after mem_ok; prefetch of 16'h0003 issued.
REQ-035 Sequential hit: after REQ-034, controller pulses cs low and requests 17'h00006 -> rom_ok one clk after cs returns, no mem_req.
REQ-036 Wrap: demand 17'h1FFFF -> prefetch mem_addr=16'h0000; a following request for 17'h00000 hits.
REQ-037 Miss during prefetch: request 17'h01000 while PREF to 16'h0003 is pending -> 16'h0003 completes first, then mem_req for 16'h0800; rom_ok never high in between.
REQ-038 Flush in flight: flush pulse during DEMAND, mem_ok 3 clk later -> data discarded, both entries invalid, and the same address is re-fetched once.
REQ-039 Address change: rom_addr changes with rom_cs held high while rom_ok=1 -> rom_ok drops in that same cycle (combinationally).
